srt_div_ctrl: RTL and testbench

- RISC-V M-extension divide front-end. Sits between the execute-stage issue logic and the unsigned radix-4 SRT divider core.
- Decodes DIV/DIVU/REM/REMU, takes operand magnitudes and resolves the architectural special cases locally.
- Sequences the core's start/finish protocol, applies sign correction, and returns one 32-bit result over a valid/ready handshake.

---
 rtl/srt_div_pkg.sv | 38 +++
 rtl/srt_div_sign_fix.sv | 89 ++++++++
 rtl/srt_div_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_srt_div_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
// ---------------------------------------------------------------------------
// srt_div_pkg
// Shared definitions for the RISC-V M-extension divide front-end:
//   - div_op_e    : request opcode encodings (DIV, DIVU, REM, REMU)
//   - div_state_e : controller FSM state encodings
//   - DIV_ZERO_Q  : quotient returned for a divide by zero (all ones)
//   - INT_MIN     : most negative signed value (0x80000000)
//   - neg_mod()   : two's-complement negation modulo 2^DATA_W
// ---------------------------------------------------------------------------
package srt_div_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_e;

   localparam logic [DATA_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [DATA_W-1:0] INT_MIN    = 32'h8000_0000;

   // Negation wraps: INT_MIN negates to itself, which is the right
   // unsigned magnitude for the core.
   function automatic logic [DATA_W-1:0] neg_mod(input logic [DATA_W-1:0] x);
      return (~x) + 32'd1;
   endfunction

endpackage

// File: rtl/srt_div_sign_fix.sv
// ---------------------------------------------------------------------------
// srt_div_sign_fix
// Combinational sign handling shared by both ends of a divide.
//   fix_mode=0 : val_a/val_b are the request operands. Produces operand
//                magnitudes, result sign flags, the special-case flag and,
//                in sel_data, the op-selected special-case result.
//   fix_mode=1 : val_a/val_b are the core quotient/remainder. sel_data is
//                the op-selected value negated per neg_q_in/neg_r_in.
// Ports:
//   op                 opcode, selects signedness and quotient/remainder
//   neg_q_in, neg_r_in stored sign flags (used in fix_mode=1)
//   abs_a, abs_b       operand magnitudes
//   neg_q, neg_r       sign flags derived from the operands
//   special            operands resolve without the core (fix_mode=0 only)
//   sel_data           selected result value
// ---------------------------------------------------------------------------
module srt_div_sign_fix
   import srt_div_pkg::*;
(
   input  logic              fix_mode,
   input  div_op_e           op,
   input  logic [DATA_W-1:0] val_a,
   input  logic [DATA_W-1:0] val_b,
   input  logic              neg_q_in,
   input  logic              neg_r_in,
   output logic [DATA_W-1:0] abs_a,
   output logic [DATA_W-1:0] abs_b,
   output logic              neg_q,
   output logic              neg_r,
   output logic              special,
   output logic [DATA_W-1:0] sel_data
);

   logic              is_signed_s;
   logic              is_rem_s;
   logic              b_zero_s;
   logic              a_zero_s;
   logic              ovf_s;
   logic [DATA_W-1:0] sp_q_s;
   logic [DATA_W-1:0] sp_r_s;
   logic [DATA_W-1:0] fix_q_s;
   logic [DATA_W-1:0] fix_r_s;

   // Op decode, magnitudes, special-case detection and result selection.
   always_comb begin
      is_signed_s = 1'b0;
      is_rem_s    = 1'b0;
      case (op)
         OP_DIV:  begin is_signed_s = 1'b1; is_rem_s = 1'b0; end
         OP_DIVU: begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
         OP_REM:  begin is_signed_s = 1'b1; is_rem_s = 1'b1; end
         OP_REMU: begin is_signed_s = 1'b0; is_rem_s = 1'b1; end
         default: begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
      endcase

      abs_a = (is_signed_s && val_a[DATA_W-1]) ? neg_mod(val_a) : val_a;
      abs_b = (is_signed_s && val_b[DATA_W-1]) ? neg_mod(val_b) : val_b;
      neg_q = is_signed_s & (val_a[DATA_W-1] ^ val_b[DATA_W-1]);
      neg_r = is_signed_s & val_a[DATA_W-1];

      b_zero_s = (val_b == 32'h0000_0000);
      a_zero_s = (val_a == 32'h0000_0000);
      ovf_s    = is_signed_s && (val_a == INT_MIN) && (val_b == DIV_ZERO_Q);

      // Divide-by-zero wins over the other cases (0/0 still yields all ones).
      if (b_zero_s) begin
         sp_q_s = DIV_ZERO_Q;
         sp_r_s = val_a;
      end else if (ovf_s) begin
         sp_q_s = INT_MIN;
         sp_r_s = 32'h0000_0000;
      end else begin
         sp_q_s = 32'h0000_0000;
         sp_r_s = 32'h0000_0000;
      end

      special = ~fix_mode & (b_zero_s | ovf_s | a_zero_s);

      fix_q_s = neg_q_in ? neg_mod(val_a) : val_a;
      fix_r_s = neg_r_in ? neg_mod(val_b) : val_b;

      if (fix_mode) begin
         sel_data = is_rem_s ? fix_r_s : fix_q_s;
      end else begin
         sel_data = is_rem_s ? sp_r_s : sp_q_s;
      end
   end

endmodule

// File: rtl/srt_div_ctrl.sv
// ---------------------------------------------------------------------------
// srt_div_ctrl
// Divide front-end between execute-stage issue and an unsigned SRT core.
// Accepts DIV/DIVU/REM/REMU, resolves divide-by-zero, signed overflow and
// zero dividend locally, otherwise runs the core start/finish protocol and
// sign-corrects the result. One result is returned per request.
// Ports:
//   req_*                 request handshake (req_ready only in IDLE, not
//                         while flush is high)
//   resp_*                response handshake, resp_data held until taken
//   flush                 kill in-flight request; result discarded
//   busy                  controller not idle
//   core_start            one-cycle start pulse to the core
//   core_dividend/divisor operand magnitudes, held while the core runs
//   core_quotient/reminder core results, sampled only on finish
//   core_finish/core_error core completion (error treated as finish)
// ---------------------------------------------------------------------------
module srt_div_ctrl
   import srt_div_pkg::*;
#(
   parameter int DW = DATA_W
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_data,
   output logic          busy,
   output logic          core_start,
   output logic [DW-1:0] core_dividend,
   output logic [DW-1:0] core_divisor,
   input  logic [DW-1:0] core_quotient,
   input  logic [DW-1:0] core_reminder,
   input  logic          core_finish,
   input  logic          core_error
);

   div_state_e    state_q,      state_d;
   div_op_e       op_q,         op_d;
   logic          neg_quo_q,    neg_quo_d;
   logic          neg_rem_q,    neg_rem_d;
   logic [DW-1:0] dividend_q,   dividend_d;
   logic [DW-1:0] divisor_q,    divisor_d;
   logic          resp_valid_q, resp_valid_d;
   logic [DW-1:0] resp_data_q,  resp_data_d;
   logic          core_start_q, core_start_d;

   logic          fix_mode_s;
   div_op_e       sf_op_s;
   logic [DW-1:0] sf_a_s;
   logic [DW-1:0] sf_b_s;
   logic [DW-1:0] abs_a_s;
   logic [DW-1:0] abs_b_s;
   logic          neg_q_s;
   logic          neg_r_s;
   logic          special_s;
   logic [DW-1:0] sel_data_s;
   logic          done_s;
   logic          accept_s;

   // One sign-fix instance: decodes the request in IDLE, corrects the core
   // result in WAIT. The two uses never overlap in time.
   assign fix_mode_s = (state_q == ST_WAIT);
   assign sf_op_s    = fix_mode_s ? op_q          : div_op_e'(req_op);
   assign sf_a_s     = fix_mode_s ? core_quotient : req_a;
   assign sf_b_s     = fix_mode_s ? core_reminder : req_b;

   srt_div_sign_fix u_sign_fix (
      .fix_mode (fix_mode_s),
      .op       (sf_op_s),
      .val_a    (sf_a_s),
      .val_b    (sf_b_s),
      .neg_q_in (neg_quo_q),
      .neg_r_in (neg_rem_q),
      .abs_a    (abs_a_s),
      .abs_b    (abs_b_s),
      .neg_q    (neg_q_s),
      .neg_r    (neg_r_s),
      .special  (special_s),
      .sel_data (sel_data_s)
   );

   assign done_s        = core_finish | core_error;
   assign req_ready     = (state_q == ST_IDLE) & ~flush;
   assign accept_s      = req_valid & req_ready;
   assign busy          = (state_q != ST_IDLE);
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign core_start    = core_start_q;
   assign core_dividend = dividend_q;
   assign core_divisor  = divisor_q;

   // Next-state, operand capture and result capture.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      neg_quo_d    = neg_quo_q;
      neg_rem_d    = neg_rem_q;
      dividend_d   = dividend_q;
      divisor_d    = divisor_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      core_start_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d      = div_op_e'(req_op);
               neg_quo_d = neg_q_s;
               neg_rem_d = neg_r_s;
               if (special_s) begin
                  resp_data_d  = sel_data_s;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  dividend_d   = abs_a_s;
                  divisor_d    = abs_b_s;
                  core_start_d = 1'b1;
                  state_d      = ST_START;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            // The core was started this cycle, so a flush must still drain it.
            if (flush) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done_s) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  resp_data_d  = sel_data_s;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (resp_ready | flush) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_DRAIN: begin
            if (done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_DIV;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         dividend_q   <= 32'h0000_0000;
         divisor_q    <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'h0000_0000;
         core_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         neg_quo_q    <= neg_quo_d;
         neg_rem_q    <= neg_rem_d;
         dividend_q   <= dividend_d;
         divisor_q    <= divisor_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         core_start_q <= core_start_d;
      end
   end

endmodule

// File: tb/tb_srt_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_srt_div_ctrl
// Self-checking bench: a behavioural divider core, a RISC-V-semantics
// reference model tracking the one outstanding request, a negedge compare
// process, directed cases with literal expectations, and a random phase.
// ---------------------------------------------------------------------------
module tb_srt_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_a = 32'h0;
   logic [31:0] req_b = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        busy;
   logic        core_start;
   logic [31:0] core_dividend;
   logic [31:0] core_divisor;
   logic [31:0] core_quotient;
   logic [31:0] core_reminder;
   logic        core_finish;
   logic        core_error = 1'b0;

   srt_div_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .busy          (busy),
      .core_start    (core_start),
      .core_dividend (core_dividend),
      .core_divisor  (core_divisor),
      .core_quotient (core_quotient),
      .core_reminder (core_reminder),
      .core_finish   (core_finish),
      .core_error    (core_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // RISC-V M-extension result semantics.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      logic sgn;
      logic rem;
      sgn = ~op[0];
      rem = op[1];
      sa  = a;
      sb  = b;
      if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
      if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
      return rem ? (a % b) : (a / b);
   endfunction

   function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (a == 32'h0) ||
             (~op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
      return (~op[0] && x[31]) ? (32'h0 - x) : x;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(7, 0))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(20, 1));
         4: return 32'h0 - 32'($urandom_range(20, 1));
         default: return $urandom;
      endcase
   endfunction

   // Reference model state and behavioural core.
   logic        pend, pend_fast, pend_ready, pend_started;
   logic [31:0] exp_data, exp_dd, exp_ds;
   logic        core_out;
   int          core_cnt;
   logic [31:0] c_dd, c_ds;
   int          lat_lo = 1;
   int          lat_hi = 6;

   // Core emulation and model update on each active edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend          <= 1'b0;
         pend_fast     <= 1'b0;
         pend_ready    <= 1'b0;
         pend_started  <= 1'b0;
         exp_data      <= 32'h0;
         exp_dd        <= 32'h0;
         exp_ds        <= 32'h0;
         core_out      <= 1'b0;
         core_cnt      <= 0;
         c_dd          <= 32'h0;
         c_ds          <= 32'h0;
         core_finish   <= 1'b0;
         core_quotient <= 32'h0;
         core_reminder <= 32'h0;
      end else begin
         // Garbage outside the finish cycle catches late sampling.
         core_quotient <= $urandom;
         core_reminder <= $urandom;
         if (core_finish) begin
            core_finish <= 1'b0;
            core_out    <= 1'b0;
         end else if (core_out) begin
            if (core_cnt <= 1) begin
               core_finish   <= 1'b1;
               core_quotient <= (c_ds == 32'h0) ? 32'hFFFF_FFFF : c_dd / c_ds;
               core_reminder <= (c_ds == 32'h0) ? c_dd : c_dd % c_ds;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
         if (core_start) begin
            core_out     <= 1'b1;
            core_cnt     <= int'($urandom_range(lat_hi, lat_lo));
            c_dd         <= core_dividend;
            c_ds         <= core_divisor;
            pend_started <= 1'b1;
         end

         if (pend && !pend_fast && core_finish && !flush) pend_ready <= 1'b1;
         if (flush || (pend && pend_ready && resp_ready)) pend <= 1'b0;
         if (req_valid && !flush && !pend && !core_out) begin
            pend         <= 1'b1;
            pend_fast    <= is_fast(req_op, req_a, req_b);
            pend_ready   <= is_fast(req_op, req_a, req_b);
            pend_started <= 1'b0;
            exp_data     <= ref_result(req_op, req_a, req_b);
            exp_dd       <= mag(req_op, req_a);
            exp_ds       <= mag(req_op, req_b);
         end
      end
   end

   // Compare DUT outputs against the model mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk1("busy", busy, pend || core_out);
         chk1("req_ready", req_ready, !(pend || core_out) && !flush);
         chk1("resp_valid", resp_valid, pend && pend_ready);
         if (pend && pend_ready) chk32("resp_data", resp_data, exp_data);
         chk1("core_start", core_start, pend && !pend_fast && !pend_started);
         if (core_start || core_out) begin
            chk32("core_dividend", core_dividend, exp_dd);
            chk32("core_divisor", core_divisor, exp_ds);
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk1({name, " idle_timeout"}, req_ready, 1'b1);
   endtask

   task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string name);
      int n;
      resp_ready = 1'b0;
      wait_idle(name);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk1({name, " resp_valid"}, resp_valid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         chk32({name, " held_data"}, resp_data, exp);
         chk1({name, " held_req_ready"}, req_ready, 1'b0);
         @(posedge clk); #1;
      end
      chk32(name, resp_data, exp);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic wait_core_start(input string name);
      int n;
      n = 0;
      while (!core_start && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk1({name, " core_start_seen"}, core_start, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst resp_valid", resp_valid, 1'b0);
      chk32("rst resp_data", resp_data, 32'h0);
      chk1("rst core_start", core_start, 1'b0);
      chk32("rst core_dividend", core_dividend, 32'h0);
      chk32("rst core_divisor", core_divisor, 32'h0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst req_ready", req_ready, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;

      run_req(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_m7_2");
      run_req(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_m7_2");
      run_req(2'b01, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
      run_req(2'b11, 32'd100, 32'd0, 32'd100, 0, "remu_by0");
      run_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
      run_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem_ovf");
      run_req(2'b00, 32'd0, 32'd5, 32'h0, 0, "div_zero_a");
      run_req(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 5, "remu_hold");
      run_req(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 0, "div_intmin_2");

      // Flush in WAIT drains the core without a response.
      lat_lo = 8;
      lat_hi = 8;
      wait_idle("flush");
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd1000; req_b = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_core_start("flush");
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk1("flush drain_busy", busy, 1'b1);
      chk1("flush no_resp", resp_valid, 1'b0);
      lat_lo = 1;
      lat_hi = 6;
      run_req(2'b01, 32'd9, 32'd3, 32'd3, 0, "divu_after_flush");

      // Asynchronous reset in WAIT.
      lat_lo = 10;
      lat_hi = 10;
      wait_idle("rst_mid");
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd50; req_b = 32'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_core_start("rst_mid");
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk1("rst_mid resp_valid", resp_valid, 1'b0);
      chk1("rst_mid busy", busy, 1'b0);
      chk1("rst_mid req_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      lat_lo = 1;
      lat_hi = 6;
      run_req(2'b10, 32'd50, 32'hFFFF_FFF9, 32'd1, 0, "rem_after_rst");

      // Random traffic with random backpressure and flushes.
      for (int c = 0; c < 3000; c++) begin
         req_valid  = 1'($urandom_range(1, 0));
         req_op     = 2'($urandom_range(3, 0));
         req_a      = pick();
         req_b      = pick();
         flush      = ($urandom_range(31, 0) == 0);
         resp_ready = 1'($urandom_range(1, 0));
         @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("final idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
